// File: rtl/sc_popcount_pkg.sv
// sc_popcount_pkg: shared FSM state encoding and count-width helper for sc_popcount_acc
package sc_popcount_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;
  function automatic int cw_f(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sc_popcount_chunk.sv
// sc_popcount_chunk: combinational ones-counter for one CHUNKWIDTH-bit slice
module sc_popcount_chunk #(
  parameter int CHUNKWIDTH = 4
) (
  input  logic [CHUNKWIDTH-1:0]            chunk_in,
  output logic [$clog2(CHUNKWIDTH+1)-1:0]  ones_out
);
  localparam int OW = $clog2(CHUNKWIDTH + 1);
  // sum the set bits of the slice
  always_comb begin
    ones_out = '0;
    for (int i = 0; i < CHUNKWIDTH; i++) ones_out = ones_out + OW'(chunk_in[i]);
  end
endmodule

// File: rtl/sc_popcount_acc.sv
// sc_popcount_acc: multi-cycle chunked popcount with optional saturating accumulator (SC_POPCOUNT_ACC_ACCUM_EN)
module sc_popcount_acc
  import sc_popcount_pkg::*;
#(
  parameter int DATAWIDTH  = 16,
  parameter int CHUNKWIDTH = 4,
  parameter int ACCWIDTH   = 8
) (
  input  logic                        sc_popcount_acc_CLOCK_50,
  input  logic                        sc_popcount_acc_RESET_InHigh,
  input  logic                        sc_popcount_acc_start_In,
  input  logic [DATAWIDTH-1:0]        sc_popcount_acc_data_In,
  input  logic                        sc_popcount_acc_clear_In,
  output logic                        sc_popcount_acc_busy_Out,
  output logic                        sc_popcount_acc_done_Out,
  output logic [cw_f(DATAWIDTH)-1:0]  sc_popcount_acc_count_Out,
  output logic [ACCWIDTH-1:0]         sc_popcount_acc_acc_Out,
  output logic                        sc_popcount_acc_accOverflow_Out
);
  localparam int N  = DATAWIDTH / CHUNKWIDTH;
  localparam int CW = cw_f(DATAWIDTH);
  localparam int OW = $clog2(CHUNKWIDTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (DATAWIDTH % CHUNKWIDTH != 0) begin : g_bad_width
    $error("DATAWIDTH must be a multiple of CHUNKWIDTH");
  end

  logic                 clk, rst;
  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        sum_q, sum_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [OW-1:0]        ones;

  assign clk = sc_popcount_acc_CLOCK_50;
  assign rst = sc_popcount_acc_RESET_InHigh;

  sc_popcount_chunk #(.CHUNKWIDTH(CHUNKWIDTH)) u_chunk (
    .chunk_in (data_q[idx_q*CHUNKWIDTH +: CHUNKWIDTH]),
    .ones_out (ones)
  );

  // FSM: latch word, walk chunks LSB first, then publish the result for one cycle
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (sc_popcount_acc_start_In) begin
        data_d  = sc_popcount_acc_data_In;
        sum_d   = '0;
        idx_d   = '0;
        state_d = COUNT;
      end
      COUNT: begin
        sum_d   = sum_q + CW'(ones);
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == IW'(N - 1)) ? DONE : COUNT;
      end
      DONE: begin
        done_d  = 1'b1;
        cnt_d   = sum_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sc_popcount_acc_busy_Out  = (state_q != IDLE);
  assign sc_popcount_acc_done_Out  = done_q;
  assign sc_popcount_acc_count_Out = cnt_q;

`ifdef SC_POPCOUNT_ACC_ACCUM_EN
  logic [ACCWIDTH-1:0] acc_q, acc_d, acc_base;
  logic                ovf_q, ovf_d, ovf_base;
  logic [ACCWIDTH:0]   acc_sum;

  // clear takes effect before a same-cycle accumulate; sum saturates at all-ones
  always_comb begin
    acc_base = sc_popcount_acc_clear_In ? '0 : acc_q;
    ovf_base = sc_popcount_acc_clear_In ? 1'b0 : ovf_q;
    acc_sum  = {1'b0, acc_base} + (ACCWIDTH+1)'(sum_q);
    acc_d    = (state_q != DONE) ? acc_base : acc_sum[ACCWIDTH] ? '1 : acc_sum[ACCWIDTH-1:0];
    ovf_d    = ovf_base | ((state_q == DONE) & acc_sum[ACCWIDTH]);
  end

  // accumulator and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign sc_popcount_acc_acc_Out         = acc_q;
  assign sc_popcount_acc_accOverflow_Out = ovf_q;
`else
  logic unused_clear;
  assign unused_clear                    = sc_popcount_acc_clear_In;
  assign sc_popcount_acc_acc_Out         = '0;
  assign sc_popcount_acc_accOverflow_Out = 1'b0;
`endif
endmodule

// File: tb/tb_sc_popcount_acc.sv
// tb_sc_popcount_acc: vector table, directed corner sequences and random traffic against a transaction-level model
module tb_sc_popcount_acc;
  localparam int DW = 16, CK = 4, AW = 8, N = DW / CK, MAXACC = 255;
`ifdef SC_POPCOUNT_ACC_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic busy, done, ovf;
  logic [4:0] cnt;
  logic [AW-1:0] acc;

  int n_chk = 0, n_err = 0;

  bit m_pend, m_done, m_ovf;
  int m_cyc, m_fin, m_cnt, m_acc;
  logic [DW-1:0] m_word;

  typedef struct {
    logic [DW-1:0] w;
    int            cnt;
    int            acc;
  } vec_t;
  vec_t tbl[6];

  sc_popcount_acc #(.DATAWIDTH(DW), .CHUNKWIDTH(CK), .ACCWIDTH(AW)) dut (
    .sc_popcount_acc_CLOCK_50        (clk),
    .sc_popcount_acc_RESET_InHigh    (rst),
    .sc_popcount_acc_start_In        (start),
    .sc_popcount_acc_data_In         (data),
    .sc_popcount_acc_clear_In        (clr),
    .sc_popcount_acc_busy_Out        (busy),
    .sc_popcount_acc_done_Out        (done),
    .sc_popcount_acc_count_Out       (cnt),
    .sc_popcount_acc_acc_Out         (acc),
    .sc_popcount_acc_accOverflow_Out (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_done = 0; m_ovf = 0;
    m_cyc = 0; m_fin = 0; m_cnt = 0; m_acc = 0; m_word = '0;
  endtask

  // one word finishes N+1 edges after its accepting edge; starts are ignored while one is in flight
  task automatic model_step();
    bit was;
    int c, s, base;
    m_cyc++;
    was = m_pend;
    m_done = 0;
    if (m_pend && m_cyc == m_fin) begin
      c = $countones(m_word);
      m_cnt = c; m_done = 1; m_pend = 0;
      if (ACC_EN) begin
        base  = clr ? 0 : m_acc;
        s     = base + c;
        m_acc = (s > MAXACC) ? MAXACC : s;
        m_ovf = (clr ? 1'b0 : m_ovf) | (s > MAXACC);
      end
    end else if (ACC_EN && clr) begin
      m_acc = 0; m_ovf = 0;
    end
    if (!was && start) begin
      m_pend = 1; m_word = data; m_fin = m_cyc + N + 1;
    end
  endtask

  task automatic cmp_all();
    chk("busy", busy, m_pend);
    chk("done", done, m_done);
    chk("count", cnt, m_cnt);
    chk("acc", acc, m_acc);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cnt, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_all();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
    chk("done_seen", done, 1);
  endtask

  task automatic run_word(input logic [DW-1:0] w, output int lat);
    start = 1'b1; data = w;
    tick();
    start = 1'b0; data = DW'($urandom);
    wait_done(lat);
  endtask

  initial begin
    int lat, nd;
    tbl[0] = '{16'h0000, 0, 0};
    tbl[1] = '{16'hA5A5, 8, 8};
    tbl[2] = '{16'hFFFF, 16, 24};
    tbl[3] = '{16'h00FF, 8, 32};
    tbl[4] = '{16'h8001, 2, 34};
    tbl[5] = '{16'h1234, 5, 39};

    do_reset();

    // single full word: latency, busy window, one-cycle done
    start = 1'b1; data = 16'hFFFF;
    tick();
    start = 1'b0; data = 16'h0000;
    chk("t34_busy_e0", busy, 1);
    for (int i = 1; i <= N; i++) begin
      tick();
      chk("t34_busy", busy, 1);
      chk("t34_nodone", done, 0);
    end
    tick();
    chk("t34_done", done, 1);
    chk("t34_count", cnt, 16);
    chk("t34_acc", acc, ACC_EN ? 16 : 0);
    tick();
    chk("t34_done_drop", done, 0);

    // vector table from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_word(tbl[i].w, lat);
      chk("tbl_latency", lat, N + 1);
      chk("tbl_count", cnt, tbl[i].cnt);
      chk("tbl_acc", acc, ACC_EN ? tbl[i].acc : 0);
    end

    // start held while busy is ignored, no queuing
    start = 1'b1; data = 16'h00FF;
    tick();
    data = 16'h0001;
    tick();
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) begin
        nd++;
        chk("t36_count", cnt, 8);
      end
    end
    chk("t36_ndone", nd, 1);

    // saturation and sticky overflow, then clear
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_word(16'hFFFF, lat);
      if (i == 14) begin
        chk("t37_acc15", acc, ACC_EN ? 240 : 0);
        chk("t37_ovf15", ovf, 0);
      end
      if (i == 15) begin
        chk("t37_acc16", acc, ACC_EN ? 255 : 0);
        chk("t37_ovf16", ovf, ACC_EN ? 1 : 0);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t37_clr_acc", acc, 0);
    chk("t37_clr_ovf", ovf, 0);

    // clear coinciding with the result cycle: clear first, then add
    for (int i = 0; i < 6; i++) run_word(16'hFFFF, lat);
    run_word(16'h000F, lat);
    chk("t38_acc100", acc, ACC_EN ? 100 : 0);
    start = 1'b1; data = 16'h000F;
    tick();
    start = 1'b0;
    for (int i = 1; i <= N; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t38_done", done, 1);
    chk("t38_count", cnt, 4);
    chk("t38_acc", acc, ACC_EN ? 4 : 0);
    chk("t38_ovf", ovf, 0);

    // reset in the middle of a count abandons it
    start = 1'b1; data = 16'hF0F0;
    tick();
    start = 1'b0;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    run_word(16'h8001, lat);
    chk("t39_latency", lat, N + 1);
    chk("t39_count", cnt, 2);
    chk("t39_acc", acc, ACC_EN ? 2 : 0);

    // random traffic, data churning during counts
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      data  = DW'($urandom);
      clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b0; clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
